// File: rtl/audio_dac_buffer_if.sv
// audio_dac_buffer_if
// Bundles the two streams around the DAC sample buffer.
//   s_data/s_valid/s_ready : user-side sample stream ({left, right} per word)
//   dacdat_req/dacdat_out  : codec transceiver side, one request pulse per frame
// Modports:
//   master : user + transceiver side (drives data, valid and requests)
//   slave  : the buffer itself
interface audio_dac_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             dacdat_req;
    logic [WIDTH-1:0] dacdat_out;

    modport master (
        output s_data,
        output s_valid,
        output dacdat_req,
        input  s_ready,
        input  dacdat_out
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  dacdat_req,
        output s_ready,
        output dacdat_out
    );
endinterface

// File: rtl/audio_dac_buffer.sv
// audio_dac_buffer
// Sample FIFO that feeds the codec transceiver's DAC path. Words are accepted over a
// valid/ready stream and handed out one per dacdat_req pulse. Silence (all zeros) is
// substituted during start-up prefill and after an underrun, so the codec never sees stale
// data.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush (empties FIFO, back to FILL, clears underrun)
//   bus         : audio_dac_buffer_if.slave (sample stream in, DAC word out)
//   level       : current FIFO occupancy
//   playing     : high while in PLAY
//   underrun    : sticky, set when a PLAY request finds the FIFO empty
//   underrun_cnt: (only with AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN) saturating count of requests
//                 served with silence once playback has started at least once
// Optional feature macro: AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
module audio_dac_buffer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PREFILL = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    audio_dac_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       playing,
    output logic                       underrun
`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StFill, StPlay} state_e;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_d;
    logic             r_underrun;
    logic             w_underrun_d;
    state_e           r_state;
    state_e           w_state_d;

    logic [LW-1:0]    w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB makes the difference span 0..DEPTH, so it is the occupancy.
    assign w_level = LW'(r_wr_ptr - r_rd_ptr);
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LW'(DEPTH));

    // Ready depends only on registered state, never on s_valid.
    assign bus.s_ready = !w_full;

    assign w_push = bus.s_valid && !w_full && !clear;
    assign w_pop  = bus.dacdat_req && (r_state == StPlay) && !w_empty && !clear;

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_dout_d     = r_dout;
        w_underrun_d = r_underrun;
        if (clear) begin
            w_state_d    = StFill;
            w_dout_d     = '0;
            w_underrun_d = 1'b0;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (bus.dacdat_req) begin
                        w_dout_d = '0;
                    end
                    if (w_level >= LW'(PREFILL)) begin
                        w_state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (bus.dacdat_req) begin
                        if (!w_empty) begin
                            w_dout_d = r_mem[r_rd_ptr[AW-1:0]];
                        end else begin
                            // A push landing this same cycle does not rescue the frame.
                            w_dout_d     = '0;
                            w_underrun_d = 1'b1;
                            w_state_d    = StFill;
                        end
                    end
                end
                default: w_state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StFill;
            r_dout     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_dout     <= w_dout_d;
            r_underrun <= w_underrun_d;
        end
    end

    assign bus.dacdat_out = r_dout;
    assign level          = w_level;
    assign playing        = (r_state == StPlay);
    assign underrun       = r_underrun;

`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
    logic        r_started;
    logic [15:0] r_cnt;
    logic        w_silent;

    // Silence is served by every FILL request and by a PLAY request on an empty FIFO.
    assign w_silent = bus.dacdat_req && !clear && ((r_state == StFill) || w_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_cnt     <= '0;
        end else if (clear) begin
            r_started <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_state == StPlay) begin
                r_started <= 1'b1;
            end
            if (w_silent && (r_started || (r_state == StPlay)) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign underrun_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_audio_dac_buffer.sv
// tb_audio_dac_buffer
// Directed self-checking bench for audio_dac_buffer (WIDTH=32, DEPTH=16, PREFILL=8).
// Inputs change just after the falling edge; outputs are checked on the falling edge.
module tb_audio_dac_buffer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [4:0]  level;
    logic        playing;
    logic        underrun;
`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_checks;
    int n_errors;

    audio_dac_buffer_if #(.WIDTH(32)) bus ();

    audio_dac_buffer #(
        .WIDTH  (32),
        .DEPTH  (16),
        .PREFILL(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .bus     (bus),
        .level   (level),
        .playing (playing),
        .underrun(underrun)
`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_word(input logic [31:0] w);
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic req_pulse();
        bus.dacdat_req = 1'b1;
        @(negedge clk);
        bus.dacdat_req = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (level !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_level: got %0d, expected 0", level);
        end
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_s_ready: got %b, expected 1", bus.s_ready);
        end
        n_checks++;
        if (bus.dacdat_out !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_dout: got %h, expected 0", bus.dacdat_out);
        end
        n_checks++;
        if (playing !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_playing: got %b, expected 0", playing);
        end
        n_checks++;
        if (underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_underrun: got %b, expected 0", underrun);
        end
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 7; i++) push_word(32'hA000_0000 + i);
        for (int i = 0; i < 3; i++) begin
            req_pulse();
            n_checks++;
            if (bus.dacdat_out !== 32'h0 || playing !== 1'b0) begin
                n_errors++;
                $display("FAIL prefill_silence[%0d]: got dout=%h playing=%b, expected 0/0",
                         i, bus.dacdat_out, playing);
            end
        end
        n_checks++;
        if (level !== 5'd7) begin
            n_errors++;
            $display("FAIL prefill_level7: got %0d, expected 7", level);
        end
        push_word(32'hA000_0007);
        n_checks++;
        if (playing !== 1'b0) begin
            n_errors++;
            $display("FAIL prefill_not_yet: got playing=%b, expected 0", playing);
        end
        @(negedge clk);
        n_checks++;
        if (playing !== 1'b1) begin
            n_errors++;
            $display("FAIL prefill_playing: got %b, expected 1", playing);
        end
        req_pulse();
        n_checks++;
        if (bus.dacdat_out !== 32'hA000_0000 || level !== 5'd7) begin
            n_errors++;
            $display("FAIL prefill_first_word: got dout=%h level=%0d, expected a0000000/7",
                     bus.dacdat_out, level);
        end
    endtask

    task automatic test_ordering();
        logic [31:0] exp;
        clear_pulse();
        for (int i = 0; i < 16; i++) push_word({16'(i + 1), 16'(i + 2)});
        for (int i = 0; i < 16; i++) begin
            exp = {16'(i + 1), 16'(i + 2)};
            req_pulse();
            n_checks++;
            if (bus.dacdat_out !== exp || level !== 5'(15 - i)) begin
                n_errors++;
                $display("FAIL order_word[%0d]: got dout=%h level=%0d, expected %h/%0d",
                         i, bus.dacdat_out, level, exp, 15 - i);
            end
            repeat (1023) @(negedge clk);
            n_checks++;
            if (bus.dacdat_out !== exp) begin
                n_errors++;
                $display("FAIL order_hold[%0d]: got %h, expected %h", i, bus.dacdat_out, exp);
            end
        end
    endtask

    task automatic test_full_simultaneous();
        clear_pulse();
        for (int i = 0; i < 16; i++) push_word(32'hF000_0000 + i);
        n_checks++;
        if (bus.s_ready !== 1'b0 || level !== 5'd16) begin
            n_errors++;
            $display("FAIL full_ready: got s_ready=%b level=%0d, expected 0/16",
                     bus.s_ready, level);
        end
        bus.s_valid    = 1'b1;
        bus.s_data     = 32'hF000_0010;
        bus.dacdat_req = 1'b1;
        @(negedge clk);
        bus.dacdat_req = 1'b0;
        n_checks++;
        if (level !== 5'd15 || bus.dacdat_out !== 32'hF000_0000 || bus.s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pop_no_push: got level=%0d dout=%h rdy=%b, expected 15/f0000000/1",
                     level, bus.dacdat_out, bus.s_ready);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        n_checks++;
        if (level !== 5'd16 || bus.s_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_refill: got level=%0d rdy=%b, expected 16/0", level, bus.s_ready);
        end
        for (int i = 1; i <= 16; i++) begin
            req_pulse();
            n_checks++;
            if (bus.dacdat_out !== 32'hF000_0000 + i) begin
                n_errors++;
                $display("FAIL full_drain[%0d]: got %h, expected %h",
                         i, bus.dacdat_out, 32'hF000_0000 + i);
            end
        end
    endtask

    task automatic test_underrun();
        clear_pulse();
        for (int i = 0; i < 8; i++) push_word(32'hC0DE_0000 + i);
        @(negedge clk);
        repeat (7) req_pulse();
        n_checks++;
        if (level !== 5'd1 || bus.dacdat_out !== 32'hC0DE_0006) begin
            n_errors++;
            $display("FAIL underrun_level1: got level=%0d dout=%h, expected 1/c0de0006",
                     level, bus.dacdat_out);
        end
        req_pulse();
        n_checks++;
        if (bus.dacdat_out !== 32'hC0DE_0007 || playing !== 1'b1 || underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_last: got dout=%h play=%b und=%b, expected c0de0007/1/0",
                     bus.dacdat_out, playing, underrun);
        end
        // Empty request with a push in the same cycle still underruns.
        bus.s_valid    = 1'b1;
        bus.s_data     = 32'hC0DE_0008;
        bus.dacdat_req = 1'b1;
        @(negedge clk);
        bus.s_valid    = 1'b0;
        bus.dacdat_req = 1'b0;
        n_checks++;
        if (bus.dacdat_out !== 32'h0 || underrun !== 1'b1 || playing !== 1'b0 ||
            level !== 5'd1) begin
            n_errors++;
            $display("FAIL underrun_empty: got dout=%h und=%b play=%b lvl=%0d, expected 0/1/0/1",
                     bus.dacdat_out, underrun, playing, level);
        end
        for (int i = 9; i < 16; i++) push_word(32'hC0DE_0000 + i);
        @(negedge clk);
        n_checks++;
        if (playing !== 1'b1 || underrun !== 1'b1 || level !== 5'd8) begin
            n_errors++;
            $display("FAIL underrun_resume: got play=%b und=%b lvl=%0d, expected 1/1/8",
                     playing, underrun, level);
        end
    endtask

    task automatic test_clear();
        req_pulse();
        n_checks++;
        if (bus.dacdat_out !== 32'hC0DE_0008) begin
            n_errors++;
            $display("FAIL clear_pre_head: got %h, expected c0de0008", bus.dacdat_out);
        end
        req_pulse();
        req_pulse();
        n_checks++;
        if (level !== 5'd5 || bus.dacdat_out !== 32'hC0DE_000A) begin
            n_errors++;
            $display("FAIL clear_pre_level: got level=%0d dout=%h, expected 5/c0de000a",
                     level, bus.dacdat_out);
        end
        clear          = 1'b1;
        bus.dacdat_req = 1'b1;
        bus.s_valid    = 1'b1;
        bus.s_data     = 32'h1234_5678;
        @(negedge clk);
        clear          = 1'b0;
        bus.dacdat_req = 1'b0;
        bus.s_valid    = 1'b0;
        n_checks++;
        if (level !== 5'd0 || bus.dacdat_out !== 32'h0 || underrun !== 1'b0 ||
            playing !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_all: got lvl=%0d dout=%h und=%b play=%b, expected 0/0/0/0",
                     level, bus.dacdat_out, underrun, playing);
        end
    endtask

`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
    task automatic test_underrun_cnt();
        for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + i);
        @(negedge clk);
        repeat (8) req_pulse();
        n_checks++;
        if (underrun_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL cnt_before: got %0d, expected 0", underrun_cnt);
        end
        repeat (3) req_pulse();
        n_checks++;
        if (underrun_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL cnt_three: got %0d, expected 3", underrun_cnt);
        end
        clear_pulse();
        n_checks++;
        if (underrun_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL cnt_clear: got %0d, expected 0", underrun_cnt);
        end
    endtask
`endif

    task automatic test_async_reset();
        clear_pulse();
        for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + i);
        @(negedge clk);
        req_pulse();
        n_checks++;
        if (bus.dacdat_out !== 32'hB000_0000 || playing !== 1'b1) begin
            n_errors++;
            $display("FAIL arst_pre: got dout=%h play=%b, expected b0000000/1",
                     bus.dacdat_out, playing);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (level !== 5'd0 || bus.s_ready !== 1'b1 || bus.dacdat_out !== 32'h0 ||
            playing !== 1'b0 || underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_values: got lvl=%0d rdy=%b dout=%h play=%b und=%b, expected 0/1/0/0/0",
                     level, bus.s_ready, bus.dacdat_out, playing, underrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        clear          = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.dacdat_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_prefill();
        test_ordering();
        test_full_simultaneous();
        test_underrun();
        test_clear();
`ifdef AUDIO_DAC_BUFFER_UNDERRUN_CNT_EN
        test_underrun_cnt();
`endif
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
